// File: rtl/tcam_array_if.sv
// rtl/tcam_array_if.sv - command/response bundle for tcam_array
interface tcam_array_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int IDX_W = $clog2(DEPTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] cmd_mask;
  logic [IDX_W-1:0] cmd_index;
  logic             rsp_valid;
  logic             rsp_ok;
  logic             rsp_multi;
  logic [IDX_W-1:0] rsp_index;
  logic [DEPTH-1:0] rsp_hits;
  logic [IDX_W:0]   count;
  logic             full;
  logic             empty;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_mask, cmd_index,
    input  cmd_ready, rsp_valid, rsp_ok, rsp_multi, rsp_index, rsp_hits, count, full, empty
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_mask, cmd_index,
    output cmd_ready, rsp_valid, rsp_ok, rsp_multi, rsp_index, rsp_hits, count, full, empty
  );
endinterface

// File: rtl/tcam_array.sv
// rtl/tcam_array.sv - ternary CAM with masked search, delete and multi-cycle flush
// TCAM_SEARCH_PIPE_EN: register the match vector and encode in a second stage (latency 2).
module tcam_array #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  tcam_array_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0]       OP_SEARCH = 2'b00;
  localparam logic [1:0]       OP_WRITE  = 2'b01;
  localparam logic [1:0]       OP_DELETE = 2'b10;
  localparam logic [1:0]       OP_FLUSH  = 2'b11;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   CNT_FULL  = (IDX_W+1)'(DEPTH);
  localparam logic [DEPTH-1:0] HIT_ONE   = DEPTH'(1);

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] mask_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [IDX_W-1:0] flush_idx_q;
  logic [IDX_W:0]   count_q;
  logic             ready, accept, flush_active, flush_last;
  logic [DEPTH-1:0] hits;
  logic             free_found, del_ok;
  logic [IDX_W-1:0] free_idx;
  logic             do_write, do_delete;

  logic             ev_valid, ev_search, ev_ok;
  logic [IDX_W-1:0] ev_index;
  logic [DEPTH-1:0] ev_hits;
  logic             src_valid, src_search, src_ok;
  logic [IDX_W-1:0] src_index;
  logic [DEPTH-1:0] src_hits;
  logic             enc_ok, enc_multi;
  logic [IDX_W-1:0] enc_index;

  logic             rsp_valid_q, rsp_ok_q, rsp_multi_q;
  logic [IDX_W-1:0] rsp_index_q;
  logic [DEPTH-1:0] rsp_hits_q;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && bus.cmd_op == OP_FLUSH) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready        = reset_n && (state_q == ST_IDLE);
    flush_active = (state_q == ST_FLUSH);
    flush_last   = flush_active && (flush_idx_q == LAST_IDX);
  end

  assign accept = bus.cmd_valid && ready;

  always_comb begin
    hits       = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++)
      hits[i] = valid_q[i] && (((data_q[i] ^ bus.cmd_data) & ~(mask_q[i] | bus.cmd_mask)) == '0);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign del_ok    = (int'(bus.cmd_index) < DEPTH) && valid_q[bus.cmd_index];
  assign do_write  = accept && (bus.cmd_op == OP_WRITE) && free_found;
  assign do_delete = accept && (bus.cmd_op == OP_DELETE) && del_ok;

  // Flush owns the storage while active; no command can be accepted then.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q     <= '0;
      count_q     <= '0;
      flush_idx_q <= '0;
    end else if (flush_active) begin
      valid_q[flush_idx_q] <= 1'b0;
      if (valid_q[flush_idx_q]) count_q <= count_q - CNT_ONE;
      flush_idx_q <= flush_last ? '0 : flush_idx_q + IDX_ONE;
    end else if (do_write) begin
      valid_q[free_idx] <= 1'b1;
      count_q           <= count_q + CNT_ONE;
    end else if (do_delete) begin
      valid_q[bus.cmd_index] <= 1'b0;
      count_q                <= count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      data_q[free_idx] <= bus.cmd_data;
      mask_q[free_idx] <= bus.cmd_mask;
    end
  end

  always_comb begin
    ev_valid  = 1'b0;
    ev_search = 1'b0;
    ev_ok     = 1'b0;
    ev_index  = '0;
    ev_hits   = '0;
    if (flush_last) begin
      ev_valid = 1'b1;
      ev_ok    = 1'b1;
      ev_index = LAST_IDX;
    end else if (accept) begin
      case (bus.cmd_op)
        OP_SEARCH: begin
          ev_valid  = 1'b1;
          ev_search = 1'b1;
          ev_hits   = hits;
        end
        OP_WRITE: begin
          ev_valid = 1'b1;
          ev_ok    = free_found;
          ev_index = free_found ? free_idx : '0;
        end
        OP_DELETE: begin
          ev_valid = 1'b1;
          ev_ok    = del_ok;
          ev_index = bus.cmd_index;
        end
        default: ;
      endcase
    end
  end

`ifdef TCAM_SEARCH_PIPE_EN
  logic             s1_valid_q, s1_search_q, s1_ok_q;
  logic [IDX_W-1:0] s1_index_q;
  logic [DEPTH-1:0] s1_hits_q;

  always_ff @(posedge clk) begin
    if (!reset_n) s1_valid_q <= 1'b0;
    else          s1_valid_q <= ev_valid;
    s1_search_q <= ev_search;
    s1_ok_q     <= ev_ok;
    s1_index_q  <= ev_index;
    s1_hits_q   <= ev_hits;
  end

  assign src_valid  = s1_valid_q;
  assign src_search = s1_search_q;
  assign src_ok     = s1_ok_q;
  assign src_index  = s1_index_q;
  assign src_hits   = s1_hits_q;
`else
  assign src_valid  = ev_valid;
  assign src_search = ev_search;
  assign src_ok     = ev_ok;
  assign src_index  = ev_index;
  assign src_hits   = ev_hits;
`endif

  always_comb begin
    enc_ok    = src_ok;
    enc_index = src_index;
    enc_multi = 1'b0;
    if (src_search) begin
      enc_ok    = |src_hits;
      enc_index = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
        if (src_hits[i]) enc_index = IDX_W'(i);
      enc_multi = |(src_hits & (src_hits - HIT_ONE));
    end
  end

  // Response fields hold their last value between strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= 1'b0;
      rsp_multi_q <= 1'b0;
      rsp_index_q <= '0;
      rsp_hits_q  <= '0;
    end else begin
      rsp_valid_q <= src_valid;
      if (src_valid) begin
        rsp_ok_q    <= enc_ok;
        rsp_multi_q <= enc_multi;
        rsp_index_q <= enc_index;
        rsp_hits_q  <= src_hits;
      end
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_ok    = rsp_ok_q;
  assign bus.rsp_multi = rsp_multi_q;
  assign bus.rsp_index = rsp_index_q;
  assign bus.rsp_hits  = rsp_hits_q;
  assign bus.count     = count_q;
  assign bus.full      = (count_q == CNT_FULL);
  assign bus.empty     = (count_q == '0);
endmodule

// File: tb/tb_tcam_array.sv
// tb/tb_tcam_array.sv - scoreboard bench for tcam_array against a table-level reference model
module tb_tcam_array;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
`ifdef TCAM_SEARCH_PIPE_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  typedef struct {
    bit          ok;
    bit          multi;
    logic [3:0]  index;
    logic [15:0] hits;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t mon_e;

  bit          m_valid [DEPTH];
  logic [15:0] m_data  [DEPTH];
  logic [15:0] m_mask  [DEPTH];
  logic [15:0] pool    [4];

  tcam_array_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  tcam_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  function automatic logic [15:0] m_valid_vec();
    logic [15:0] v = '0;
    for (int i = 0; i < DEPTH; i++) v[i] = m_valid[i];
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  // Monitor: pops one expectation per response strobe and checks arrival cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      n_checks++;
      $display("FAIL rsp_missing: no response by cycle %0d, due %0d", cyc, sb[0].due);
      sb.delete(0);
    end
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL rsp_unexpected: response at cycle %0d with nothing pending", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_latency", 64'(cyc), 64'(mon_e.due));
        chk("rsp_ok", bus.rsp_ok, mon_e.ok);
        chk("rsp_multi", bus.rsp_multi, mon_e.multi);
        chk("rsp_index", bus.rsp_index, mon_e.index);
        chk("rsp_hits", bus.rsp_hits, mon_e.hits);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] d, input logic [15:0] m,
                       input logic [3:0] idx, input bit expect_rsp);
    exp_t e;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_mask  = m;
    bus.cmd_index = idx;
    @(negedge clk);
    chk("cmd_ready", bus.cmd_ready, 1'b1);
    e.ok = 1'b0; e.multi = 1'b0; e.index = '0; e.hits = '0; e.due = cyc + L;
    case (op)
      OP_SEARCH: begin
        for (int i = 0; i < DEPTH; i++)
          e.hits[i] = m_valid[i] && (((m_data[i] ^ d) & ~(m_mask[i] | m)) == 16'h0);
        e.ok    = (e.hits != 16'h0);
        e.multi = ($countones(e.hits) > 1);
        for (int i = DEPTH - 1; i >= 0; i--) if (e.hits[i]) e.index = 4'(i);
      end
      OP_WRITE: begin
        for (int i = DEPTH - 1; i >= 0; i--)
          if (!m_valid[i]) begin e.ok = 1'b1; e.index = 4'(i); end
        if (e.ok) begin
          m_valid[e.index] = 1'b1;
          m_data[e.index]  = d;
          m_mask[e.index]  = m;
        end
      end
      OP_DELETE: begin
        e.index = idx;
        e.ok    = m_valid[idx];
        m_valid[idx] = 1'b0;
      end
      default: begin
        e.ok    = 1'b1;
        e.index = 4'(DEPTH - 1);
        e.due   = cyc + DEPTH + L;
      end
    endcase
    if (expect_rsp) sb.push_back(e);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("count", bus.count, 64'(m_cnt()));
    chk("full", bus.full, m_cnt() == DEPTH);
    chk("empty", bus.empty, m_cnt() == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input bit abort);
    issue(OP_FLUSH, 16'h0, 16'h0, 4'h0, !abort);
    if (!abort) begin
      for (int k = 0; k < DEPTH; k++) begin
        @(negedge clk);
        chk("flush_ready_low", bus.cmd_ready, 1'b0);
      end
      m_clear();
      @(negedge clk);
      chk("flush_ready_back", bus.cmd_ready, 1'b1);
      chk("flush_count", bus.count, 0);
      chk("flush_empty", bus.empty, 1'b1);
      @(posedge clk); #1;
    end else begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk("abort_ready_low", bus.cmd_ready, 1'b0);
      end
      @(posedge clk); #1;
      reset_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        chk("abort_reset_ready", bus.cmd_ready, 1'b0);
        @(posedge clk); #1;
      end
      reset_n = 1'b1;
      m_clear();
      @(negedge clk);
      chk("abort_ready_back", bus.cmd_ready, 1'b1);
      chk("abort_count", bus.count, 0);
      chk("abort_empty", bus.empty, 1'b1);
      chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
      @(posedge clk); #1;
      idle(DEPTH + 4);
    end
  endtask

  initial begin
    logic [15:0] d, m;
    int r;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_SEARCH;
    bus.cmd_data  = '0;
    bus.cmd_mask  = '0;
    bus.cmd_index = '0;
    pool[0] = 16'hA5A5; pool[1] = 16'h3C3C; pool[2] = 16'h0F0F; pool[3] = 16'hFFFF;
    m_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_ok", bus.rsp_ok, 1'b0);
    chk("reset_rsp_multi", bus.rsp_multi, 1'b0);
    chk("reset_rsp_index", bus.rsp_index, 0);
    chk("reset_rsp_hits", bus.rsp_hits, 0);
    chk("reset_count", bus.count, 0);
    chk("reset_empty", bus.empty, 1'b1);
    chk("reset_full", bus.full, 1'b0);
    chk("reset_ready", bus.cmd_ready, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);

    issue(OP_WRITE, 16'hA5A5, 16'h0000, 4'h0, 1'b1);
    issue(OP_WRITE, 16'hA500, 16'h00FF, 4'h0, 1'b1);
    issue(OP_SEARCH, 16'hA5A5, 16'h0000, 4'h0, 1'b1);
    issue(OP_SEARCH, 16'hA511, 16'h0000, 4'h0, 1'b1);

    for (int i = 2; i < DEPTH; i++) issue(OP_WRITE, 16'($urandom), 16'h0, 4'h0, 1'b1);
    issue(OP_WRITE, 16'h1111, 16'h0, 4'h0, 1'b1);
    issue(OP_DELETE, 16'h0, 16'h0, 4'd5, 1'b1);
    issue(OP_WRITE, 16'h5555, 16'h0, 4'h0, 1'b1);
    issue(OP_DELETE, 16'h0, 16'h0, 4'd3, 1'b1);
    issue(OP_DELETE, 16'h0, 16'h0, 4'd3, 1'b1);
    issue(OP_SEARCH, 16'h1234, 16'hFFFF, 4'h0, 1'b1);
    issue(OP_WRITE, 16'hBEEF, 16'h0, 4'h0, 1'b1);
    issue(OP_SEARCH, 16'hBEEF, 16'h0, 4'h0, 1'b1);
    idle(L + 1);

    do_flush(1'b0);

    for (int n = 0; n < 400; n++) begin
      d = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) d = d ^ (16'h1 << $urandom_range(0, 15));
      m = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom & $urandom) : 16'h0;
      r = $urandom_range(0, 99);
      if (r < 45)      issue(OP_SEARCH, d, m, 4'h0, 1'b1);
      else if (r < 75) issue(OP_WRITE, d, m, 4'h0, 1'b1);
      else             issue(OP_DELETE, d, m, 4'($urandom_range(0, DEPTH - 1)), 1'b1);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    issue(OP_SEARCH, 16'h0, 16'hFFFF, 4'h0, 1'b1);
    idle(L + 1);

    for (int i = 0; i < DEPTH; i++) issue(OP_WRITE, 16'($urandom), 16'h0, 4'h0, 1'b1);
    issue(OP_SEARCH, 16'h0, 16'hFFFF, 4'h0, 1'b1);
    do_flush(1'b0);
    chk("valid_model_empty", 64'(m_valid_vec()), 0);

    for (int i = 0; i < 6; i++) issue(OP_WRITE, 16'($urandom), 16'h0, 4'h0, 1'b1);
    idle(L + 1);
    do_flush(1'b1);
    issue(OP_WRITE, 16'h7777, 16'h0, 4'h0, 1'b1);
    issue(OP_SEARCH, 16'h7777, 16'h0, 4'h0, 1'b1);

    idle(DEPTH + 4);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tcam_array.md
# tcam_array

Parametrised ternary CAM with per-entry don't-care masks, search-time global masking, explicit delete, multi-cycle flush and a prioritised hit result. It is the next-generation lookup store for the lab's match/classification datapath. Commands arrive over a valid/ready port, one per cycle. Every accepted command returns exactly one response at a fixed latency.

## Interface
- `WIDTH`, 16: key/data width in bits.
- `DEPTH`, 16: number of entries, ≥2.
- `IDX_W`, `$clog2(DEPTH)`: entry index width; derived, never overridden.
- `clk` in 1: sole clock; all state updates on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block accepts a command this cycle.
- `cmd_op` in 2: 00 SEARCH, 01 WRITE, 10 DELETE, 11 FLUSH.
- `cmd_data` in WIDTH: search key (SEARCH) or stored data (WRITE).
- `cmd_mask` in WIDTH: 1 = don't-care bit; global key mask (SEARCH) or entry mask (WRITE).
- `cmd_index` in IDX_W: target entry (DELETE only).
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_ok` out 1: operation succeeded / search hit.
- `rsp_multi` out 1: more than one entry matched.
- `rsp_index` out IDX_W: lowest matching entry (SEARCH) or entry written/deleted.
- `rsp_hits` out DEPTH: full match vector (SEARCH); 0 for other ops.
- `count` out IDX_W+1: number of valid entries.
- `full`, `empty` out 1 each: `count==DEPTH`, `count==0`.

## Operation
- Storage: per entry `data[WIDTH]`, `mask[WIDTH]`, `valid`. Only `valid` is reset; data and mask are not.
- Accept: `cmd_valid && cmd_ready`. At most one command per cycle.
- Match: entry i matches when `valid[i]` and `((data[i] ^ key) & ~(mask[i] | cmd_mask)) == 0`.
- SEARCH: compares against the storage state before the accepting edge.
  - `rsp_hits` is the match vector.
  - `rsp_ok` = any match; `rsp_index` = lowest matching index (0 on miss).
  - `rsp_multi` = popcount > 1.
- WRITE: takes the lowest-index invalid entry, stores data and mask, sets valid. Response: `rsp_ok=1`, `rsp_index`=slot. When full: no state change, `rsp_ok=0`, `rsp_index=0`. Identical duplicate entries are permitted.
- DELETE: clears `valid[cmd_index]`. `rsp_ok=1` if the entry was valid, else 0. `rsp_index=cmd_index`. An index ≥ DEPTH gives `rsp_ok=0` and no state change.
- FLUSH: FSM moves IDLE→FLUSH and clears one entry per cycle, index 0..DEPTH-1.
  - `cmd_ready=0` while in FLUSH.
  - Returns to IDLE after clearing entry DEPTH-1.
  - Response issued at the usual latency after the last clear, with `rsp_ok=1`, `rsp_index=DEPTH-1`.
- FSM: IDLE (ready=1) → FLUSH on accepted op 11; FLUSH stays for DEPTH cycles → IDLE.
- `count` tracks valid entries: +1 on successful write, −1 on successful delete or per valid entry cleared in flush. It never wraps.

## Timing
- Reset (`reset_n=0` at an edge): all valid bits 0, FSM=IDLE.
  - `rsp_valid=0`, `rsp_ok=0`, `rsp_multi=0`, `rsp_index=0`, `rsp_hits=0`, `count=0`, `empty=1`, `full=0`.
  - `cmd_ready=0` during reset cycles.
- Reset mid-FLUSH aborts the flush; no response is issued. Any pending pipeline response is dropped.
- Latency L: `rsp_valid` is asserted L cycles after the accepting edge. L=1 without the pipe option, L=2 with it. Response fields are valid only while `rsp_valid=1` and hold their values otherwise.
- Write/delete state is visible to a SEARCH accepted the next cycle (back-to-back is allowed).
- `count`, `full` and `empty` update on the edge that changes storage.
- Response order equals command order. There is no response back-pressure.

## Configuration
- `TCAM_SEARCH_PIPE_EN`:
  - Defined: the match vector is registered, and the priority encode and popcount happen in a second stage, so L=2. Throughput stays at one command per cycle.
  - Undefined: match, encode and popcount are computed combinationally from the accepted command and registered once, so L=1.
  - Functional results are identical in both builds.

## Test plan
- Reset, then WRITE data 0xA5A5 mask 0x0000 and WRITE data 0xA500 mask 0x00FF → responses ok=1 with index 0, then ok=1 with index 1; `count=2`.
- SEARCH key 0xA5A5 mask 0 → `rsp_hits=0x0003`, ok=1, index 0, multi=1. SEARCH 0xA511 → `hits=0x0002`, index 1, multi=0.
- Fill DEPTH=16 entries → `full=1`. A 17th WRITE → ok=0 with count unchanged. DELETE 5 then WRITE → index 5.
- DELETE an already-invalid entry 3 → ok=0 and count unchanged. SEARCH with `cmd_mask=0xFFFF` → hits equals the valid vector.
- FLUSH with 16 entries → `cmd_ready=0` for 16 cycles, then the response ok=1, `count=0`, `empty=1`. Assert `reset_n=0` mid-FLUSH in a second run → no response, `cmd_ready` returns after reset.
- Back-to-back WRITE then SEARCH of the same key in consecutive cycles → the search hits. Response latency is checked at 1 and 2 cycles with `TCAM_SEARCH_PIPE_EN` undefined and defined.
